// File: rtl/eq2_chk_pkg.sv
// Shared definitions for the eq2 response checker: FSM state encoding and
// sweep-size helper.
package eq2_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Number of {a,b} vectors in a full sweep for operand width w.
  function automatic int unsigned num_vec(input int unsigned w);
    return 32'd1 << (2 * w);
  endfunction

endpackage

// File: rtl/eq2_settle_timer.sv
// Settle-interval counter: counts enabled cycles and flags the last one of
// each SETTLE_CYCLES-long window.
module eq2_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the final settle cycle, so the FSM moves to CHECK on that edge.
  assign expire = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/eq2_response_checker.sv
// Self-test engine for the 2-bit equality comparator: sweeps every {a,b}
// pair, samples aeqb after a settle interval and records the verdict.
module eq2_response_checker
  import eq2_chk_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic                 aeqb_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail_vec,
  output logic                 first_fail_valid
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned CW = IW + 1;

  localparam logic [IW-1:0] IDX_LAST = {IW{1'b1}};
  localparam logic [IW-1:0] IDX_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ERR_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q,    state_d;
  logic [IW-1:0] idx_q,      idx_d;
  logic [CW-1:0] err_q,      err_d;
  logic [IW-1:0] ff_vec_q,   ff_vec_d;
  logic          ff_valid_q, ff_valid_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;

  logic          expire_s;
  logic          mismatch_s;

  eq2_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q != SETTLE),
    .enable  (state_q == SETTLE),
    .expire  (expire_s)
  );

  assign mismatch_s = aeqb_in != (idx_q[IW-1:WIDTH] == idx_q[WIDTH-1:0]);

  // Sweep sequencing, error accounting and first-failure capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d      = {IW{1'b0}};
          err_d      = {CW{1'b0}};
          ff_vec_d   = {IW{1'b0}};
          ff_valid_d = 1'b0;
          state_d    = SETTLE;
        end else begin
          state_d    = state_q;
        end
      end
      SETTLE: begin
        if (expire_s) begin
          state_d = CHECK;
        end else begin
          state_d = SETTLE;
        end
      end
      CHECK: begin
        if (mismatch_s) begin
          err_d = err_q + ERR_ONE;
          if (!ff_valid_q) begin
            ff_vec_d   = idx_q;
            ff_valid_d = 1'b1;
          end else begin
            ff_vec_d   = ff_vec_q;
          end
        end else begin
          err_d = err_q;
        end
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= {IW{1'b0}};
      err_q      <= {CW{1'b0}};
      ff_vec_q   <= {IW{1'b0}};
      ff_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign a_out            = idx_q[IW-1:WIDTH];
  assign b_out            = idx_q[WIDTH-1:0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q && (err_q == {CW{1'b0}});
  assign err_count        = err_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_eq2_response_checker.sv
// Scoreboard bench: two checkers (SETTLE_CYCLES 4 and 1) driving a modelled
// comparator whose faults are described by a per-vector corruption mask.
module tb_eq2_response_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        start0, start1;
  logic [1:0]  a0, b0, a1, b1;
  logic        busy0, busy1, done0, done1, pass0, pass1;
  logic [4:0]  err0, err1;
  logic [3:0]  ffv0, ffv1;
  logic        ffval0, ffval1;
  logic [15:0] mask0, mask1;
  logic        aeqb0, aeqb1;

  // Comparator model: true equality, flipped wherever the fault mask is set.
  assign aeqb0 = (a0 == b0) ^ mask0[{a0, b0}];
  assign aeqb1 = (a1 == b1) ^ mask1[{a1, b1}];

  eq2_response_checker #(.WIDTH(2), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start0), .a_out(a0), .b_out(b0),
    .aeqb_in(aeqb0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0), .first_fail_valid(ffval0));

  eq2_response_checker #(.WIDTH(2), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .a_out(a1), .b_out(b1),
    .aeqb_in(aeqb1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1), .first_fail_valid(ffval1));

  logic       busy_w [2];
  logic       done_w [2];
  logic       pass_w [2];
  logic [3:0] idx_w  [2];
  logic [4:0] err_w  [2];
  logic [3:0] ffv_w  [2];
  logic       ffval_w[2];
  assign busy_w[0] = busy0;  assign busy_w[1] = busy1;
  assign done_w[0] = done0;  assign done_w[1] = done1;
  assign pass_w[0] = pass0;  assign pass_w[1] = pass1;
  assign idx_w[0]  = {a0, b0}; assign idx_w[1] = {a1, b1};
  assign err_w[0]  = err0;   assign err_w[1]  = err1;
  assign ffv_w[0]  = ffv0;   assign ffv_w[1]  = ffv1;
  assign ffval_w[0] = ffval0; assign ffval_w[1] = ffval1;

  int sett[2] = '{4, 1};
  int len [2] = '{80, 32};

  typedef struct {
    int dut;
    int k;
    int err;
    int first;
    int valid;
    int pss;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int d, input int k, input logic [15:0] m);
    exp_t e;
    e.dut = d; e.k = k; e.err = 0; e.first = 0; e.valid = 0;
    for (int v = 0; v < 16; v++) begin
      if (m[v]) begin
        e.err++;
        if (e.valid == 0) begin
          e.first = v;
          e.valid = 1;
        end
      end
    end
    e.pss = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic int find(input int d);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].dut == d) return i;
    end
    return -1;
  endfunction

  // Monitor: expected busy window and vector from the sweep start cycle; verdict on done rise.
  logic done_prev[2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    int   h;
    logic ebusy;
    for (int d = 0; d < 2; d++) begin
      h = find(d);
      ebusy = 1'b0;
      if (h >= 0) ebusy = (cyc >= sb[h].k) && (cyc < sb[h].k + len[d]);
      chk($sformatf("d%0d_busy", d), busy_w[d], ebusy);
      if (ebusy) chk($sformatf("d%0d_vec", d), idx_w[d], (cyc - sb[h].k) / (sett[d] + 1));
      if (!done_w[d]) chk($sformatf("d%0d_pass_low", d), pass_w[d], 0);
      if (done_w[d] && !done_prev[d]) begin
        if (h < 0) begin
          checks++;
          errors++;
          $display("FAIL d%0d_unexpected_done actual=1 required=0 (cycle %0d)", d, cyc);
        end else begin
          chk($sformatf("d%0d_done_cycle", d), cyc, sb[h].k + len[d]);
          chk($sformatf("d%0d_err_count", d), err_w[d], sb[h].err);
          chk($sformatf("d%0d_first_vec", d), ffv_w[d], sb[h].first);
          chk($sformatf("d%0d_first_valid", d), ffval_w[d], sb[h].valid);
          chk($sformatf("d%0d_pass", d), pass_w[d], sb[h].pss);
          sb.delete(h);
        end
      end
      done_prev[d] = done_w[d];
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_a0"}, a0, 0);       chk({nm, "_b0"}, b0, 0);
    chk({nm, "_busy0"}, busy0, 0); chk({nm, "_done0"}, done0, 0);
    chk({nm, "_pass0"}, pass0, 0); chk({nm, "_err0"}, err0, 0);
    chk({nm, "_ffv0"}, ffv0, 0);   chk({nm, "_ffval0"}, ffval0, 0);
    chk({nm, "_a1"}, a1, 0);       chk({nm, "_b1"}, b1, 0);
    chk({nm, "_busy1"}, busy1, 0); chk({nm, "_done1"}, done1, 0);
    chk({nm, "_pass1"}, pass1, 0); chk({nm, "_err1"}, err1, 0);
    chk({nm, "_ffv1"}, ffv1, 0);   chk({nm, "_ffval1"}, ffval1, 0);
  endtask

  task automatic start_sweep(input int d, input logic [15:0] m, input int width);
    @(negedge clk); #1;
    if (d == 0) mask0 = m; else mask1 = m;
    sb.push_back(model(d, cyc + 1, m));
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    repeat (width) @(negedge clk);
    if (d == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      if (find(d) < 0) return;
    end
    checks++;
    errors++;
    $display("FAIL d%0d_timeout actual=pending required=done (cycle %0d)", d, cyc);
    while (find(d) >= 0) sb.delete(find(d));
  endtask

  initial begin
    logic [15:0] m;
    int          k;
    reset_n = 1'b1; start0 = 1'b0; start1 = 1'b0;
    mask0 = 16'h0000; mask1 = 16'h0000;
    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Golden comparator, then stuck-at-0, stuck-at-1 and inverted outputs.
    start_sweep(0, 16'h0000, 1); wait_idle(0);
    chk("t1_pass", pass0, 1); chk("t1_err", err0, 0); chk("t1_valid", ffval0, 0);
    start_sweep(0, 16'h8421, 1); wait_idle(0);
    chk("t2_err", err0, 4); chk("t2_first", ffv0, 0); chk("t2_valid", ffval0, 1); chk("t2_pass", pass0, 0);
    start_sweep(0, 16'h7BDE, 2); wait_idle(0);
    chk("t3_err", err0, 12); chk("t3_first", ffv0, 1); chk("t3_pass", pass0, 0);
    start_sweep(0, 16'hFFFF, 1); wait_idle(0);
    chk("t4_err", err0, 16); chk("t4_first", ffv0, 0); chk("t4_pass", pass0, 0);
    start_sweep(0, 16'h0000, 1); #1;
    chk("t4_clr_err", err0, 0); chk("t4_clr_valid", ffval0, 0); chk("t4_clr_done", done0, 0);
    wait_idle(0);
    chk("t4_restart_pass", pass0, 1);

    // Reset mid-SETTLE aborts the sweep before the next clock edge.
    start_sweep(0, 16'h0000, 1);
    repeat (29) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1 chk_zero("midreset");
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #1 chk_zero("post_reset_idle");
    start_sweep(0, 16'h0000, 1); wait_idle(0);
    chk("t5_pass", pass0, 1);

    // Held start: ignored while busy, re-triggers on the first edge in DONE.
    @(negedge clk); #1;
    m = 16'($urandom);
    mask0 = m;
    k = cyc + 1;
    sb.push_back(model(0, k, m));
    sb.push_back(model(0, k + 81, m));
    start0 = 1'b1;
    for (int t = 0; t < 400 && cyc < k + 161; t++) begin
      @(negedge clk); #1;
    end
    start0 = 1'b0;
    wait_idle(0);
    repeat (5) @(negedge clk);

    // SETTLE_CYCLES=1 instance, then randomized fault masks on both.
    start_sweep(1, 16'h0000, 1); wait_idle(1);
    chk("t6_s1_pass", pass1, 1);
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       m = 16'h0000;
        1:       m = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: m = 16'($urandom);
      endcase
      start_sweep(i % 2, m, $urandom_range(1, 4));
      wait_idle(i % 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
